// File: rtl/hiscore_arb_pkg.sv
// hiscore_arb_pkg: shared state type, default widths and width helper for the hiscore RAM arbiter
package hiscore_arb_pkg;
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_SETTLE, S_GRANT, S_RELEASE} arb_state_t;
  localparam int DEF_ADDR_W  = 16;
  localparam int DEF_DATA_W  = 8;
  localparam int DEF_SETTLE  = 4;
  localparam int DEF_TIMEOUT = 4096;
  // ceil(log2(v)) clamped to at least one bit so a counter is never zero-width
  function automatic int clog2_sat(input int v);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) w = i + 1;
    return (w < 1) ? 1 : w;
  endfunction
endpackage

// File: rtl/hs_port_mux.sv
// hs_port_mux: combinational RAM port mux between CPU and hiscore engine
// Ports: sel (1 = hiscore owns port), cpu_* CPU side, hs_* hiscore side, ram_* muxed RAM port.
module hs_port_mux
  import hiscore_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              sel,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_dout,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] hs_address,
  input  logic [DATA_W-1:0] hs_data_in,
  input  logic              hs_write_enable,
  input  logic              hs_write_intent,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_we
);
  always_comb begin
    ram_addr = sel ? hs_address : cpu_addr;
    ram_din  = sel ? hs_data_in : cpu_dout;
    // a stray write strobe without a write intent must never reach the RAM
    ram_we   = sel ? (hs_write_enable & hs_write_intent) : cpu_we;
  end
endmodule

// File: rtl/hiscore_ram_arbiter.sv
// hiscore_ram_arbiter: pauses the CPU and hands the work-RAM port to the hiscore engine
// Ports: clk_sys/reset_n (async active-low); cpu_* CPU RAM side and cpu_idle boundary flag;
// ram_* muxed RAM port (ram_q 1-cycle sync read); hs_* hiscore intents, access and read data;
// hs_grant/hs_pause session status; timeout_err sticky forced-grant flag.
module hiscore_ram_arbiter
  import hiscore_arb_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int SETTLE  = DEF_SETTLE,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_dout,
  input  logic              cpu_we,
  input  logic              cpu_idle,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_q,
  input  logic              hs_read_intent,
  input  logic              hs_write_intent,
  input  logic [ADDR_W-1:0] hs_address,
  input  logic [DATA_W-1:0] hs_data_in,
  input  logic              hs_write_enable,
  output logic [DATA_W-1:0] hs_data_out,
  output logic              hs_rd_valid,
  output logic              hs_grant,
  output logic              hs_pause,
  output logic              timeout_err
);
  localparam int TW = clog2_sat(TIMEOUT);
  localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT - 1);
  localparam logic [3:0] S_MAX = 4'(SETTLE - 1);
  arb_state_t state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [3:0] settle_cnt_q, settle_cnt_d;
  logic hs_grant_q, hs_grant_d;
  logic hs_pause_q, hs_pause_d;
  logic rd_pipe_q, rd_pipe_d;
  logic hs_rd_valid_q, hs_rd_valid_d;
  logic timeout_err_q, timeout_err_d;
  logic [DATA_W-1:0] hs_data_out_q, hs_data_out_d;
  logic intent;
  assign intent = hs_read_intent | hs_write_intent;
  always_comb begin
    state_d = state_q;
    timeout_err_d = timeout_err_q;
    case (state_q)
      S_IDLE:    state_d = intent ? S_REQ : S_IDLE;
      S_REQ: begin
        if (!intent) state_d = S_RELEASE;
        else if (cpu_idle) state_d = S_SETTLE;
        else if (timer_q == T_MAX) begin
          // CPU never reached a boundary: force the grant and flag it
          state_d = S_SETTLE;
          timeout_err_d = 1'b1;
        end
      end
      S_SETTLE:  state_d = !intent ? S_RELEASE : (settle_cnt_q == S_MAX) ? S_GRANT : S_SETTLE;
      S_GRANT:   state_d = intent ? S_GRANT : S_RELEASE;
      // always pass through IDLE so the CPU gets at least one unpaused cycle
      S_RELEASE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
    // both counters saturate and restart on every state entry
    timer_d = (state_d != state_q) ? '0 : (&timer_q) ? timer_q : timer_q + 1'b1;
    settle_cnt_d = (state_d != state_q) ? '0 : (&settle_cnt_q) ? settle_cnt_q : settle_cnt_q + 1'b1;
    hs_grant_d = state_d == S_GRANT;
    hs_pause_d = state_d != S_IDLE;
    // address sampled by the RAM this cycle; its data arrives next cycle and is registered the cycle after
    rd_pipe_d = (state_q == S_GRANT) && (state_d == S_GRANT) && hs_read_intent;
    hs_rd_valid_d = rd_pipe_q && (state_d == S_GRANT);
    hs_data_out_d = hs_rd_valid_d ? ram_q : hs_data_out_q;
  end
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      timer_q       <= '0;
      settle_cnt_q  <= '0;
      hs_grant_q    <= 1'b0;
      hs_pause_q    <= 1'b0;
      rd_pipe_q     <= 1'b0;
      hs_rd_valid_q <= 1'b0;
      timeout_err_q <= 1'b0;
      hs_data_out_q <= '0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      settle_cnt_q  <= settle_cnt_d;
      hs_grant_q    <= hs_grant_d;
      hs_pause_q    <= hs_pause_d;
      rd_pipe_q     <= rd_pipe_d;
      hs_rd_valid_q <= hs_rd_valid_d;
      timeout_err_q <= timeout_err_d;
      hs_data_out_q <= hs_data_out_d;
    end
  end
  assign hs_grant    = hs_grant_q;
  assign hs_pause    = hs_pause_q;
  assign hs_rd_valid = hs_rd_valid_q;
  assign timeout_err = timeout_err_q;
  assign hs_data_out = hs_data_out_q;
  hs_port_mux #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_mux (
    .sel             (hs_grant_q),
    .cpu_addr        (cpu_addr),
    .cpu_dout        (cpu_dout),
    .cpu_we          (cpu_we),
    .hs_address      (hs_address),
    .hs_data_in      (hs_data_in),
    .hs_write_enable (hs_write_enable),
    .hs_write_intent (hs_write_intent),
    .ram_addr        (ram_addr),
    .ram_din         (ram_din),
    .ram_we          (ram_we)
  );
endmodule

// File: tb/tb_hiscore_ram_arbiter.sv
// tb_hiscore_ram_arbiter: directed self-checking bench for hiscore_ram_arbiter
module tb_hiscore_ram_arbiter;
  logic clk_sys = 1'b0;
  logic reset_n;
  logic [15:0] cpu_addr;
  logic [7:0] cpu_dout;
  logic cpu_we, cpu_idle;
  logic [15:0] ram_addr;
  logic [7:0] ram_din;
  logic ram_we;
  logic [7:0] ram_q;
  logic hs_read_intent, hs_write_intent, hs_write_enable;
  logic [15:0] hs_address;
  logic [7:0] hs_data_in;
  logic [7:0] hs_data_out;
  logic hs_rd_valid, hs_grant, hs_pause, timeout_err;
  logic [7:0] mem [0:65535];
  int checks = 0;
  int failures = 0;
  always #5 clk_sys = ~clk_sys;
  always @(posedge clk_sys) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_q <= mem[ram_addr];
  end
  hiscore_ram_arbiter #(.ADDR_W(16), .DATA_W(8), .SETTLE(4), .TIMEOUT(16)) dut (
    .clk_sys         (clk_sys),
    .reset_n         (reset_n),
    .cpu_addr        (cpu_addr),
    .cpu_dout        (cpu_dout),
    .cpu_we          (cpu_we),
    .cpu_idle        (cpu_idle),
    .ram_addr        (ram_addr),
    .ram_din         (ram_din),
    .ram_we          (ram_we),
    .ram_q           (ram_q),
    .hs_read_intent  (hs_read_intent),
    .hs_write_intent (hs_write_intent),
    .hs_address      (hs_address),
    .hs_data_in      (hs_data_in),
    .hs_write_enable (hs_write_enable),
    .hs_data_out     (hs_data_out),
    .hs_rd_valid     (hs_rd_valid),
    .hs_grant        (hs_grant),
    .hs_pause        (hs_pause),
    .timeout_err     (timeout_err)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk_sys);
    @(negedge clk_sys);
  endtask
  initial begin
    reset_n = 1'b0;
    cpu_addr = 16'h0042;
    cpu_dout = 8'h00;
    cpu_we = 1'b0;
    cpu_idle = 1'b0;
    hs_read_intent = 1'b0;
    hs_write_intent = 1'b0;
    hs_write_enable = 1'b0;
    hs_address = 16'h0000;
    hs_data_in = 8'h00;
    @(negedge clk_sys);
    @(negedge clk_sys);
    chk("rst_pause", hs_pause, 0);
    chk("rst_grant", hs_grant, 0);
    chk("rst_valid", hs_rd_valid, 0);
    chk("rst_terr", timeout_err, 0);
    chk("rst_dout", hs_data_out, 0);
    chk("rst_mux", ram_addr, 16'h0042);
    reset_n = 1'b1;
    cpu_we = 1'b1;
    cpu_addr = 16'h6010;
    cpu_dout = 8'h5A;
    #1;
    chk("cpu_addr", ram_addr, 16'h6010);
    chk("cpu_din", ram_din, 8'h5A);
    chk("cpu_we", ram_we, 1);
    tick();
    chk("cpu_pause", hs_pause, 0);
    chk("cpu_grant", hs_grant, 0);
    chk("cpu_mem", mem[16'h6010], 8'h5A);
    cpu_addr = 16'h6000; cpu_dout = 8'hA5; tick();
    cpu_addr = 16'h6001; cpu_dout = 8'h3C; tick();
    cpu_addr = 16'h6200; cpu_dout = 8'h11; tick();
    cpu_we = 1'b0;
    cpu_addr = 16'h0000;
    cpu_idle = 1'b1;
    hs_read_intent = 1'b1;
    hs_address = 16'h6000;
    tick();
    chk("rd_req_pause", hs_pause, 1);
    chk("rd_req_grant", hs_grant, 0);
    for (int i = 2; i <= 5; i++) begin
      tick();
      chk("rd_settle_grant", hs_grant, 0);
    end
    tick();
    chk("rd_grant", hs_grant, 1);
    chk("rd_mux_addr", ram_addr, 16'h6000);
    chk("rd_mux_we", ram_we, 0);
    tick();
    chk("rd_n1_valid", hs_rd_valid, 0);
    hs_address = 16'h6001;
    tick();
    chk("rd_n2_valid", hs_rd_valid, 1);
    chk("rd_n2_data", hs_data_out, 8'hA5);
    tick();
    chk("rd_pipe_valid", hs_rd_valid, 1);
    chk("rd_pipe_data", hs_data_out, 8'h3C);
    hs_read_intent = 1'b0;
    tick();
    chk("rd_rel_grant", hs_grant, 0);
    chk("rd_rel_pause", hs_pause, 1);
    chk("rd_rel_flush", hs_rd_valid, 0);
    tick();
    chk("rd_idle_pause", hs_pause, 0);
    chk("rd_idle_mux", ram_addr, 16'h0000);
    hs_write_intent = 1'b1;
    hs_write_enable = 1'b1;
    hs_address = 16'h6100;
    hs_data_in = 8'h33;
    #1;
    chk("wr_pre_we", ram_we, 0);
    repeat (5) tick();
    chk("wr_pre_grant", hs_grant, 0);
    tick();
    chk("wr_grant", hs_grant, 1);
    chk("wr_mux_addr", ram_addr, 16'h6100);
    chk("wr_mux_din", ram_din, 8'h33);
    chk("wr_mux_we", ram_we, 1);
    tick();
    chk("wr_mem", mem[16'h6100], 8'h33);
    hs_write_intent = 1'b0;
    hs_write_enable = 1'b0;
    tick();
    chk("wr_rel_grant", hs_grant, 0);
    chk("wr_rel_pause", hs_pause, 1);
    cpu_addr = 16'h0777;
    #1;
    chk("wr_rel_mux", ram_addr, 16'h0777);
    hs_write_intent = 1'b1;
    cpu_idle = 1'b0;
    tick();
    chk("regrant_gap_pause", hs_pause, 0);
    for (int i = 1; i <= 21; i++) begin
      tick();
      if (i == 1) chk("to_req_pause", hs_pause, 1);
      if (i == 16) chk("to_terr_early", timeout_err, 0);
      if (i == 17) chk("to_terr_set", timeout_err, 1);
      if (i == 20) chk("to_grant_early", hs_grant, 0);
      if (i == 21) chk("to_grant", hs_grant, 1);
    end
    hs_write_intent = 1'b0;
    tick();
    tick();
    chk("to_idle_pause", hs_pause, 0);
    chk("to_terr_sticky", timeout_err, 1);
    cpu_idle = 1'b1;
    hs_write_intent = 1'b1;
    hs_write_enable = 1'b1;
    hs_address = 16'h6200;
    hs_data_in = 8'h77;
    tick();
    tick();
    chk("st_we", ram_we, 0);
    hs_write_intent = 1'b0;
    tick();
    chk("st_rel_grant", hs_grant, 0);
    chk("st_rel_pause", hs_pause, 1);
    tick();
    chk("st_idle_pause", hs_pause, 0);
    chk("st_mem", mem[16'h6200], 8'h11);
    hs_write_enable = 1'b0;
    hs_read_intent = 1'b1;
    hs_address = 16'h6000;
    repeat (6) tick();
    chk("mr_grant", hs_grant, 1);
    tick();
    tick();
    chk("mr_valid", hs_rd_valid, 1);
    chk("mr_data", hs_data_out, 8'hA5);
    cpu_addr = 16'h1234;
    reset_n = 1'b0;
    #1;
    chk("mr_pause", hs_pause, 0);
    chk("mr_grant0", hs_grant, 0);
    chk("mr_valid0", hs_rd_valid, 0);
    chk("mr_terr0", timeout_err, 0);
    chk("mr_dout0", hs_data_out, 0);
    chk("mr_mux", ram_addr, 16'h1234);
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
